// File: rtl/multdiv_pkg.sv
// Shared constants for the execute-stage multiply/divide unit.
// Op encodings, FSM state codes and iteration counts.
package multdiv_pkg;

    localparam int WIDTH      = 32;
    localparam int MULT_ITERS = WIDTH / 2;
    localparam int DIV_ITERS  = WIDTH;
    localparam int CNT_W      = 6;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    function automatic logic [WIDTH-1:0] apply_sign(
        input logic             neg,
        input logic [WIDTH-1:0] v
    );
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth digit selector.
// Maps one multiplier triplet to a 34-bit signed partial product.
module booth_r4_sel
    import multdiv_pkg::*;
(
    input  logic [2:0]       trip,
    input  logic [WIDTH+1:0] a,
    output logic [WIDTH+1:0] pp
);

    always_comb begin
        pp = '0;
        unique case (trip)
            3'b001, 3'b010: pp = a;
            3'b011:         pp = a << 1;
            3'b100:         pp = -(a << 1);
            3'b101, 3'b110: pp = -a;
            default:        pp = '0;
        endcase
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multi-cycle signed MULT (radix-4 Booth) / DIV (restoring) owning HI/LO.
// Define MULTDIV_DIVZERO_EXC_EN for the fast divide-by-zero exception path.
module mult_div_ctrl
    import multdiv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
`ifdef MULTDIV_DIVZERO_EXC_EN
    output logic             div_zero_o,
`endif
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               op_q;
    logic               sa;
    logic               sb;
    logic               dz;
    logic [WIDTH+1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               b_prev;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH+1:0]   pp;
    logic [2*WIDTH-1:0] pp_ext;
    logic [5:0]         shamt;
    logic [WIDTH:0]     sh;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   q_fin;
    logic [WIDTH-1:0]   r_fin;

    booth_r4_sel u_sel (
        .trip ({b_q[1], b_q[0], b_prev}),
        .a    (a_q),
        .pp   (pp)
    );

    // acc is {remainder, quotient-shift} during DIV
    assign pp_ext = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
    assign shamt  = {cnt[4:0], 1'b0};
    assign sh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff   = sh - {1'b0, b_q};
    assign ge     = !diff[WIDTH];
    assign q_fin  = apply_sign(sa ^ sb, acc[WIDTH-1:0]);
    assign r_fin  = apply_sign(sa, acc[2*WIDTH-1:WIDTH]);
    assign busy_o = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= OP_MULT;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dz     <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            b_prev <= 1'b0;
            acc    <= '0;
            done_o <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
`ifdef MULTDIV_DIVZERO_EXC_EN
            div_zero_o <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
`ifdef MULTDIV_DIVZERO_EXC_EN
            div_zero_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q    <= {{2{a_i[WIDTH-1]}}, a_i};
                        op_q   <= op_i;
                        sa     <= a_i[WIDTH-1];
                        sb     <= b_i[WIDTH-1];
                        dz     <= (op_i == OP_DIV) && (b_i == '0);
                        cnt    <= '0;
                        b_prev <= 1'b0;
                        if (op_i == OP_MULT) begin
                            b_q   <= b_i;
                            acc   <= '0;
                            state <= MULT;
                        end else begin
                            b_q   <= apply_sign(b_i[WIDTH-1], b_i);
                            acc   <= {{WIDTH{1'b0}},
                                      apply_sign(a_i[WIDTH-1], a_i)};
                            state <= DIV;
                        end
                    end
                end
                MULT: begin
                    acc    <= acc + (pp_ext << shamt);
                    b_q    <= {2'b00, b_q[WIDTH-1:2]};
                    b_prev <= b_q[1];
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(MULT_ITERS - 1))
                        state <= FIN;
                end
                DIV: begin
`ifdef MULTDIV_DIVZERO_EXC_EN
                    if (dz)
                        state <= FIN;
                    else
`endif
                    begin
                        acc <= ge ? {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                  : {sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(DIV_ITERS - 1))
                            state <= FIN;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    done_o <= 1'b1;
                    if (op_q == OP_MULT) begin
                        hi_o <= acc[2*WIDTH-1:WIDTH];
                        lo_o <= acc[WIDTH-1:0];
                    end else if (dz) begin
`ifdef MULTDIV_DIVZERO_EXC_EN
                        div_zero_o <= 1'b1;
`else
                        hi_o <= a_q[WIDTH-1:0];
                        lo_o <= '1;
`endif
                    end else begin
                        hi_o <= r_fin;
                        lo_o <= q_fin;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed + random ops vs arithmetic model.
// Works with or without MULTDIV_DIVZERO_EXC_EN defined.
module tb_mult_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic        op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
`ifdef MULTDIV_DIVZERO_EXC_EN
    logic        div_zero_o;
    localparam bit DZ_EXC = 1'b1;
`else
    localparam bit DZ_EXC = 1'b0;
`endif

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    always #5 clk = ~clk;

    mult_div_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
`ifdef MULTDIV_DIVZERO_EXC_EN
        .div_zero_o (div_zero_o),
`endif
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: plain signed arithmetic on 64-bit values.
    task automatic model(input logic op, input logic [31:0] a,
                         input logic [31:0] b);
        longint x;
        longint y;
        longint p;
        x = longint'($signed(a));
        y = longint'($signed(b));
        if (op == 1'b0) begin
            p    = x * y;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (b == 32'd0) begin
            if (!DZ_EXC) begin
                m_hi = a;
                m_lo = 32'hFFFF_FFFF;
            end
        end else begin
            p    = x / y;
            m_lo = p[31:0];
            p    = x % y;
            m_hi = p[31:0];
        end
    endtask

    task automatic run(input string tag, input logic op,
                       input logic [31:0] a, input logic [31:0] b);
        int lat;
        int bsy;
        int exp_lat;
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i     = $urandom;
        b_i     = $urandom;
        op_i    = 1'($urandom);
        lat = 0;
        bsy = 0;
        while (!done_o && lat < 100) begin
            if (busy_o) bsy++;
            @(posedge clk);
            #1;
            lat++;
        end
        model(op, a, b);
        exp_lat = (op == 1'b0) ? 17 : ((DZ_EXC && b == 0) ? 2 : 33);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(bsy), 64'(exp_lat));
        chk({tag, "_hi"}, 64'(hi_o), 64'(m_hi));
        chk({tag, "_lo"}, 64'(lo_o), 64'(m_lo));
`ifdef MULTDIV_DIVZERO_EXC_EN
        chk({tag, "_dz"}, 64'(div_zero_o), 64'(op && b == 0));
`endif
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'({done_o, busy_o}), 64'd0);
        chk({tag, "_hold"}, {hi_o, lo_o}, {m_hi, m_lo});
    endtask

    initial begin
        int d1;
        int d2;
        int ndone;
        logic [31:0] l1;
        logic [31:0] l2;
        logic [31:0] ra;
        logic [31:0] rb;

        reset   = 1'b1;
        start_i = 1'b0;
        op_i    = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {30'd0, busy_o, done_o, hi_o, lo_o}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run("mul_7x6", 1'b0, 32'd7, 32'd6);
        run("mul_m3x5", 1'b0, 32'hFFFF_FFFD, 32'd5);
        run("mul_min2", 1'b0, 32'h8000_0000, 32'h8000_0000);
        run("div_m7d2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run("div_100dm7", 1'b1, 32'd100, 32'hFFFF_FFF9);
        run("div_5d0", 1'b1, 32'd5, 32'd0);
        run("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run("div_small", 1'b1, 32'd3, 32'hFFFF_FFF0);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = 32'($signed($urandom_range(0, 16)) - 8);
            run($sformatf("rmul%0d", i), 1'b0, ra, rb);
        end
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) rb = rb >> $urandom_range(4, 30);
            if (i % 3 == 2) rb = 32'($signed($urandom_range(0, 8)) - 4);
            run($sformatf("rdiv%0d", i), 1'b1, ra, rb);
        end

        // start held high; operands changed while busy must not leak in
        @(negedge clk);
        start_i = 1'b1;
        op_i    = 1'b0;
        a_i     = 32'd3;
        b_i     = 32'd3;
        @(posedge clk);
        #1;
        a_i = 32'd5;
        b_i = 32'd5;
        d1 = -1;
        d2 = -1;
        l1 = '0;
        l2 = '0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == 17) chk("held_busy_e17", 64'(busy_o), 64'd0);
            if (e == 18) chk("held_busy_e18", 64'(busy_o), 64'd1);
            if (done_o && d1 < 0) begin
                d1 = e;
                l1 = lo_o;
            end else if (done_o && d2 < 0) begin
                d2 = e;
                l2 = lo_o;
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        chk("held_d1", 64'(d1), 64'd17);
        chk("held_lo1", 64'(l1), 64'd9);
        chk("held_d2", 64'(d2), 64'd35);
        chk("held_lo2", 64'(l2), 64'd25);
        chk("held_idle", 64'(busy_o), 64'd0);

        // reset in the middle of a DIV
        @(negedge clk);
        start_i = 1'b1;
        op_i    = 1'b1;
        a_i     = 32'd1000;
        b_i     = 32'd7;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
        end
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid", {30'd0, busy_o, done_o, hi_o, lo_o}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (done_o || busy_o) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'd0);
        run("post_rst_mul", 1'b0, 32'hFFFF_FFFD, 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
